// File: rtl/updown_pkg.sv
// Shared state encoding and default geometry for the up/down sequence monitor.
package updown_pkg;

    localparam int unsigned LO_DEF = 5;
    localparam int unsigned HI_DEF = 31;
    localparam int unsigned W_DEF  = 5;
    localparam int unsigned CW_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: holds at all-ones instead of rolling over.
module sat_counter #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] cnt
);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/updown_seq_monitor.sv
// Checks that an observed up/down counter steps by one and wraps between LO and HI,
// counting wraps and latching the first deviation.
module updown_seq_monitor
    import updown_pkg::*;
#(
    parameter int unsigned LO = LO_DEF,
    parameter int unsigned HI = HI_DEF,
    parameter int unsigned W  = W_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  q_in,
    input  logic          mode_in,
    input  logic          load_in,
    input  logic          clr,
    output logic [CW-1:0] wrap_up_cnt,
    output logic [CW-1:0] wrap_dn_cnt,
    output logic          err,
    output logic [W-1:0]  err_val,
    output logic [W-1:0]  err_exp,
    output logic [1:0]    st
);

    localparam logic [W-1:0] LO_W = W'(LO);
    localparam logic [W-1:0] HI_W = W'(HI);

    state_t       r_st;
    logic [W-1:0] r_prev;
    logic         r_err;
    logic [W-1:0] r_err_val;
    logic [W-1:0] r_err_exp;

    state_t       w_st_nxt;
    logic [W-1:0] w_prev_nxt;
    logic         w_err_nxt;
    logic [W-1:0] w_err_val_nxt;
    logic [W-1:0] w_err_exp_nxt;
    logic         w_inc_up;
    logic         w_inc_dn;
    logic [W-1:0] w_exp;
    logic         w_in_range;
    logic         w_at_hi;
    logic         w_at_lo;

    // Next-value predictor; +1/-1 only applied away from the wrap points.
    always_comb begin
        w_at_hi    = (r_prev == HI_W);
        w_at_lo    = (r_prev == LO_W);
        w_in_range = (q_in >= LO_W) && (q_in <= HI_W);
        if (mode_in) begin
            w_exp = w_at_hi ? LO_W : (r_prev + W'(1));
        end else begin
            w_exp = w_at_lo ? HI_W : (r_prev - W'(1));
        end
    end

    always_comb begin
        w_st_nxt      = r_st;
        w_prev_nxt    = r_prev;
        w_err_nxt     = r_err;
        w_err_val_nxt = r_err_val;
        w_err_exp_nxt = r_err_exp;
        w_inc_up      = 1'b0;
        w_inc_dn      = 1'b0;

        if (clr) begin
            w_st_nxt      = ST_IDLE;
            w_err_nxt     = 1'b0;
            w_err_val_nxt = '0;
            w_err_exp_nxt = '0;
        end else begin
            case (r_st)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (w_in_range) begin
                            w_prev_nxt = q_in;
                            w_st_nxt   = ST_TRACK;
                        end else begin
                            w_st_nxt      = ST_FAULT;
                            w_err_nxt     = 1'b1;
                            w_err_val_nxt = q_in;
                            w_err_exp_nxt = '0;
                        end
                    end
                end
                ST_TRACK: begin
                    if (in_valid) begin
                        if (load_in) begin
                            if (w_in_range) begin
                                w_prev_nxt = q_in;
                            end else begin
                                w_st_nxt      = ST_FAULT;
                                w_err_nxt     = 1'b1;
                                w_err_val_nxt = q_in;
                                w_err_exp_nxt = '0;
                            end
                        end else if (q_in == w_exp) begin
                            w_prev_nxt = q_in;
                            w_inc_up   = mode_in && w_at_hi;
                            w_inc_dn   = !mode_in && w_at_lo;
                        end else begin
                            w_st_nxt      = ST_FAULT;
                            w_err_nxt     = 1'b1;
                            w_err_val_nxt = q_in;
                            w_err_exp_nxt = w_exp;
                        end
                    end
                end
                ST_FAULT: begin
                    w_st_nxt = ST_FAULT;
                end
                default: begin
                    w_st_nxt = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st      <= ST_IDLE;
            r_prev    <= LO_W;
            r_err     <= 1'b0;
            r_err_val <= '0;
            r_err_exp <= '0;
        end else begin
            r_st      <= w_st_nxt;
            r_prev    <= w_prev_nxt;
            r_err     <= w_err_nxt;
            r_err_val <= w_err_val_nxt;
            r_err_exp <= w_err_exp_nxt;
        end
    end

    sat_counter #(.CW(CW)) u_wrap_up (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (w_inc_up),
        .cnt (wrap_up_cnt)
    );

    sat_counter #(.CW(CW)) u_wrap_dn (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (w_inc_dn),
        .cnt (wrap_dn_cnt)
    );

    assign err     = r_err;
    assign err_val = r_err_val;
    assign err_exp = r_err_exp;
    assign st      = r_st;

endmodule

// File: tb/tb_updown_seq_monitor.sv
// Scoreboard bench: each driven cycle queues its hand-computed expected outputs,
// a monitor pops and compares one entry per clock.
module tb_updown_seq_monitor;

    typedef struct packed {
        logic [1:0] st;
        logic [7:0] up;
        logic [7:0] dn;
        logic       err;
        logic [4:0] val;
        logic [4:0] ex;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [4:0] q_in = '0;
    logic       mode_in = 1'b0;
    logic       load_in = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] wrap_up_cnt;
    logic [7:0] wrap_dn_cnt;
    logic       err;
    logic [4:0] err_val;
    logic [4:0] err_exp;
    logic [1:0] st;

    int n_tests = 0;
    int n_fail  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    updown_seq_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .q_in        (q_in),
        .mode_in     (mode_in),
        .load_in     (load_in),
        .clr         (clr),
        .wrap_up_cnt (wrap_up_cnt),
        .wrap_dn_cnt (wrap_dn_cnt),
        .err         (err),
        .err_val     (err_val),
        .err_exp     (err_exp),
        .st          (st)
    );

    function automatic exp_t mk(input int s, input int up, input int dn,
                                input int e, input int v, input int x);
        exp_t r;
        r.st  = 2'(s);
        r.up  = 8'(up);
        r.dn  = 8'(dn);
        r.err = 1'(e);
        r.val = 5'(v);
        r.ex  = 5'(x);
        return r;
    endfunction

    // Drive one cycle of stimulus on the falling edge and queue its expected result.
    task automatic step(input logic v, input int q, input logic m, input logic ld,
                        input logic c, input logic r, input exp_t e);
        @(negedge clk);
        in_valid = v;
        q_in     = 5'(q);
        mode_in  = m;
        load_in  = ld;
        clr      = c;
        rst      = r;
        sb.push_back(e);
    endtask

    task automatic up(input int q, input exp_t e);
        step(1'b1, q, 1'b1, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic dn(input int q, input exp_t e);
        step(1'b1, q, 1'b0, 1'b0, 1'b0, 1'b0, e);
    endtask

    task automatic do_clr();
        step(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 0, 0));
    endtask

    // Monitor: outputs settle 1 time unit after each rising edge.
    initial begin : monitor
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a = {st, wrap_up_cnt, wrap_dn_cnt, err, err_val, err_exp};
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL chk%0d: got st=%0d up=%0d dn=%0d err=%0d val=%0d exp=%0d, want st=%0d up=%0d dn=%0d err=%0d val=%0d exp=%0d",
                             n_tests, a.st, a.up, a.dn, a.err, a.val, a.ex,
                             e.st, e.up, e.dn, e.err, e.val, e.ex);
                end
            end
        end
    end

    initial begin : stim
        int wraps;
        int drain;
        exp_t z;
        z = mk(0, 0, 0, 0, 0, 0);

        // Reset state
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, z);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, z);

        // Up-wrap HI->LO
        up(29, mk(1, 0, 0, 0, 0, 0));
        up(30, mk(1, 0, 0, 0, 0, 0));
        up(31, mk(1, 0, 0, 0, 0, 0));
        up(5,  mk(1, 1, 0, 0, 0, 0));
        up(6,  mk(1, 1, 0, 0, 0, 0));
        // Invalid cycle carrying a would-be-fault value must be ignored
        step(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, mk(1, 1, 0, 0, 0, 0));
        do_clr();

        // Down-wrap LO->HI
        dn(6,  mk(1, 0, 0, 0, 0, 0));
        dn(5,  mk(1, 0, 0, 0, 0, 0));
        dn(31, mk(1, 0, 1, 0, 0, 0));
        dn(30, mk(1, 0, 1, 0, 0, 0));
        do_clr();

        // Step fault, then FAULT ignores samples
        up(10, mk(1, 0, 0, 0, 0, 0));
        up(11, mk(1, 0, 0, 0, 0, 0));
        up(13, mk(2, 0, 0, 1, 13, 12));
        up(14, mk(2, 0, 0, 1, 13, 12));
        // clr beats a same-cycle valid sample in FAULT
        step(1'b1, 17, 1'b1, 1'b0, 1'b1, 1'b0, z);

        // Load resync and range fault on load
        up(20, mk(1, 0, 0, 0, 0, 0));
        step(1'b1, 7, 1'b1, 1'b1, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0));
        up(8,  mk(1, 0, 0, 0, 0, 0));
        step(1'b1, 31, 1'b0, 1'b1, 1'b0, 1'b0, mk(1, 0, 0, 0, 0, 0));
        dn(30, mk(1, 0, 0, 0, 0, 0));
        step(1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0, mk(2, 0, 0, 1, 3, 0));
        // rst in FAULT
        step(1'b1, 9, 1'b1, 1'b0, 1'b0, 1'b1, z);

        // IDLE range fault just below LO
        up(4, mk(2, 0, 0, 1, 4, 0));
        do_clr();

        // Down from LO must predict HI
        dn(6, mk(1, 0, 0, 0, 0, 0));
        dn(5, mk(1, 0, 0, 0, 0, 0));
        dn(4, mk(2, 0, 0, 1, 4, 31));
        do_clr();

        // Up from HI must predict LO
        up(31, mk(1, 0, 0, 0, 0, 0));
        up(6,  mk(2, 0, 0, 1, 6, 5));
        do_clr();

        // rst beats clr and valid mid-TRACK with a nonzero counter
        up(30, mk(1, 0, 0, 0, 0, 0));
        up(31, mk(1, 0, 0, 0, 0, 0));
        up(5,  mk(1, 1, 0, 0, 0, 0));
        step(1'b1, 6, 1'b1, 1'b0, 1'b1, 1'b1, z);
        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, z);

        // Saturation over 300 up-wraps
        up(5, mk(1, 0, 0, 0, 0, 0));
        for (int w = 1; w <= 300; w++) begin
            wraps = (w - 1 > 255) ? 255 : w - 1;
            for (int v = 6; v <= 31; v++) begin
                up(v, mk(1, wraps, 0, 0, 0, 0));
            end
            wraps = (w > 255) ? 255 : w;
            up(5, mk(1, wraps, 0, 0, 0, 0));
        end

        step(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1, 255, 0, 0, 0, 0));

        drain = 0;
        while (sb.size() > 0 && drain < 20) begin
            @(posedge clk);
            drain++;
        end
        #2;
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
